// File: rtl/serial_byte_receiver_if.sv
// Parallel-side and line-side signals of the serial byte receiver.
// master = CPU/line driver side, slave = the receiver itself.
interface serial_byte_receiver_if #(
   parameter int DATA_BITS = 8
);
   logic                 rx_serial;
   logic                 byte_ack;
   logic                 clear_errors;
   logic [DATA_BITS-1:0] byte_out;
   logic                 byte_strobe;
   logic                 byte_ready;
   logic                 busy;
   logic                 sample_bit;
   logic                 framing_error;
   logic                 overrun;

   modport master (
      output rx_serial,
      output byte_ack,
      output clear_errors,
      input  byte_out,
      input  byte_strobe,
      input  byte_ready,
      input  busy,
      input  sample_bit,
      input  framing_error,
      input  overrun
   );

   modport slave (
      input  rx_serial,
      input  byte_ack,
      input  clear_errors,
      output byte_out,
      output byte_strobe,
      output byte_ready,
      output busy,
      output sample_bit,
      output framing_error,
      output overrun
   );
endinterface

// File: rtl/serial_byte_receiver.sv
// Oversampling serial receiver: sync, start detect, mid-bit sampling, stop check,
// parallel byte hand-off with strobe, ready/ack hold and sticky error flags.
module serial_byte_receiver #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   serial_byte_receiver_if.slave link
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t               state_q;
   state_t               state_d;
   logic [1:0]           sync_q;
   logic                 rx_s;
   logic [CW-1:0]        cnt_q;
   logic [BW-1:0]        bit_cnt_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic [DATA_BITS-1:0] byte_out_q;
   logic                 byte_strobe_q;
   logic                 byte_ready_q;
   logic                 framing_q;
   logic                 overrun_q;

   logic tick_mid;
   logic tick_bit;
   logic last_bit;
   logic busy_c;
   logic sample_c;
   logic shift_en;
   logic stop_good;
   logic stop_bad;

   // Synchroniser idles high so reset never looks like a start bit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], link.rx_serial};
      end
   end

   assign rx_s     = sync_q[1];
   assign tick_mid = (cnt_q == MID_CNT);
   assign tick_bit = (cnt_q == LAST_CNT);
   assign last_bit = (bit_cnt_q == LAST_BIT);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
            end
         end
         START: begin
            if (tick_mid) begin
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick_bit && last_bit) begin
               state_d = STOP;
            end
         end
         STOP: begin
            if (tick_bit) begin
               state_d = rx_s ? IDLE : BREAK;
            end
         end
         BREAK: begin
            if (rx_s) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_c    = (state_q != IDLE);
      sample_c  = 1'b0;
      shift_en  = 1'b0;
      stop_good = 1'b0;
      stop_bad  = 1'b0;
      case (state_q)
         DATA: begin
            sample_c = tick_bit;
            shift_en = tick_bit;
         end
         STOP: begin
            stop_good = tick_bit & rx_s;
            stop_bad  = tick_bit & ~rx_s;
         end
         default: begin
            sample_c = 1'b0;
         end
      endcase
   end

   // The IDLE cycle that sees the low line is cycle 0, so START counts from 1
   // and its counter value equals the cycle number since the start edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE:       cnt_q <= rx_s ? '0 : CW'(1);
            START:      cnt_q <= tick_mid ? '0 : cnt_q + CW'(1);
            DATA, STOP: cnt_q <= tick_bit ? '0 : cnt_q + CW'(1);
            default:    cnt_q <= '0;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bit_cnt_q <= '0;
      end else if (state_q == START) begin
         bit_cnt_q <= '0;
      end else if (shift_en) begin
         bit_cnt_q <= last_bit ? '0 : bit_cnt_q + BW'(1);
      end
   end

   // LSB arrives first, so each new bit enters at the top and moves down.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shreg_q <= '0;
      end else if (shift_en) begin
         shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         byte_out_q    <= '0;
         byte_strobe_q <= 1'b0;
         byte_ready_q  <= 1'b0;
      end else begin
         byte_strobe_q <= stop_good;
         if (stop_good) begin
            byte_out_q   <= shreg_q;
            byte_ready_q <= 1'b1;
         end else if (link.byte_ack) begin
            byte_ready_q <= 1'b0;
         end
      end
   end

   // An ack landing with the new byte consumed the old one, so no overrun.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         framing_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         framing_q <= (framing_q & ~link.clear_errors) | stop_bad;
         overrun_q <= (overrun_q & ~link.clear_errors)
                    | (stop_good & byte_ready_q & ~link.byte_ack);
      end
   end

   assign link.byte_out      = byte_out_q;
   assign link.byte_strobe   = byte_strobe_q;
   assign link.byte_ready    = byte_ready_q;
   assign link.busy          = busy_c;
   assign link.sample_bit    = sample_c;
   assign link.framing_error = framing_q;
   assign link.overrun       = overrun_q;
endmodule

// File: tb/tb_serial_byte_receiver.sv
// Bench for serial_byte_receiver: frames are built as per-clock line levels,
// outputs are compared with a frame-level model of byte/ready/error state.
module tb_serial_byte_receiver;
   localparam int OVS  = 16;
   localparam int DB   = 8;
   localparam int SYNC = 2;
   localparam int BIG  = 1000000;
   localparam int STROBE_LAT = OVS * (DB + 1) + OVS / 2;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   serial_byte_receiver_if #(.DATA_BITS(DB)) link ();

   serial_byte_receiver #(.OVERSAMPLE(OVS), .DATA_BITS(DB)) dut (
      .clock(clock),
      .reset(reset),
      .link (link)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clock) cyc <= cyc + 1;

   bit       line_q[$];
   int       strobe_cyc[$];
   logic [7:0] strobe_dat[$];
   int       fall_cyc[$];
   int       n_samples;
   int       busy_cycles;

   logic [7:0] m_out;
   bit         m_ready, m_ovr, m_fe;

   task automatic push_level(input bit v, input int n);
      for (int i = 0; i < n; i++) line_q.push_back(v);
   endtask

   task automatic push_frame(input logic [7:0] d, input bit stop);
      push_level(1'b0, OVS);
      for (int i = 0; i < DB; i++) push_level(d[i], OVS);
      push_level(stop, OVS);
   endtask

   // Model of a received frame at the byte level.
   task automatic model_frame(input logic [7:0] d, input bit good, input bit ack_same);
      if (!good) begin
         m_fe = 1'b1;
      end else begin
         if (m_ready && !ack_same) m_ovr = 1'b1;
         m_out   = d;
         m_ready = 1'b1;
      end
   endtask

   task automatic play(input int max_iter, input int ack_iter, input int clr_iter);
      bit prev;
      bit v;
      int it;
      strobe_cyc.delete();
      strobe_dat.delete();
      fall_cyc.delete();
      n_samples   = 0;
      busy_cycles = 0;
      prev = link.rx_serial;
      it   = 0;
      while (line_q.size() > 0 && it < max_iter) begin
         v = line_q.pop_front();
         link.rx_serial = v;
         if (prev && !v) fall_cyc.push_back(cyc);
         prev = v;
         link.byte_ack     = (it == ack_iter);
         link.clear_errors = (it == clr_iter);
         @(posedge clock);
         #1;
         if (link.byte_strobe) begin
            strobe_cyc.push_back(cyc);
            strobe_dat.push_back(link.byte_out);
         end
         if (link.sample_bit) n_samples++;
         if (link.busy) busy_cycles++;
         it++;
      end
      link.byte_ack     = 1'b0;
      link.clear_errors = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      link.rx_serial = 1'b1;
      link.byte_ack = 1'b0;
      link.clear_errors = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      total++; if (link.byte_out !== 8'h00) begin bad++; $display("FAIL reset_byte_out got=%h exp=00", link.byte_out); end
      total++; if (link.byte_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b exp=0", link.byte_strobe); end
      total++; if (link.byte_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", link.byte_ready); end
      total++; if (link.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", link.busy); end
      total++; if (link.sample_bit !== 1'b0) begin bad++; $display("FAIL reset_sample got=%b exp=0", link.sample_bit); end
      total++; if (link.framing_error !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b exp=0", link.framing_error); end
      total++; if (link.overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", link.overrun); end
      m_out = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
   endtask

   task automatic test_single_a5;
      int lat;
      push_level(1'b1, 4);
      push_frame(8'hA5, 1'b1);
      push_level(1'b1, 8);
      play(BIG, -1, -1);
      model_frame(8'hA5, 1'b1, 1'b0);
      lat = (strobe_cyc.size() > 0 && fall_cyc.size() > 0) ? strobe_cyc[0] - fall_cyc[0] - SYNC : -1;
      total++; if (strobe_cyc.size() !== 1) begin bad++; $display("FAIL a5_strobe_count got=%0d exp=1", strobe_cyc.size()); end
      total++; if (lat !== STROBE_LAT) begin bad++; $display("FAIL a5_strobe_cycle got=%0d exp=%0d", lat, STROBE_LAT); end
      total++; if (n_samples !== DB) begin bad++; $display("FAIL a5_samples got=%0d exp=%0d", n_samples, DB); end
      total++; if (link.byte_out !== m_out) begin bad++; $display("FAIL a5_byte_out got=%h exp=%h", link.byte_out, m_out); end
      total++; if (link.byte_ready !== m_ready) begin bad++; $display("FAIL a5_ready got=%b exp=%b", link.byte_ready, m_ready); end
      total++; if ({link.framing_error, link.overrun} !== {m_fe, m_ovr}) begin bad++; $display("FAIL a5_errors got=%b%b exp=%b%b", link.framing_error, link.overrun, m_fe, m_ovr); end
   endtask

   task automatic test_glitch;
      push_level(1'b1, 4);
      push_level(1'b0, 4);
      push_level(1'b1, 30);
      play(BIG, -1, -1);
      total++; if (busy_cycles !== OVS / 2 - 1) begin bad++; $display("FAIL glitch_busy_cycles got=%0d exp=%0d", busy_cycles, OVS / 2 - 1); end
      total++; if (n_samples !== 0) begin bad++; $display("FAIL glitch_samples got=%0d exp=0", n_samples); end
      total++; if (strobe_cyc.size() !== 0) begin bad++; $display("FAIL glitch_strobes got=%0d exp=0", strobe_cyc.size()); end
      total++; if (link.byte_out !== m_out) begin bad++; $display("FAIL glitch_byte_out got=%h exp=%h", link.byte_out, m_out); end
   endtask

   task automatic test_framing;
      push_level(1'b1, 4);
      push_frame(8'h3C, 1'b0);
      push_level(1'b0, OVS);
      push_level(1'b1, 10);
      play(BIG, -1, -1);
      model_frame(8'h3C, 1'b0, 1'b0);
      total++; if (link.framing_error !== m_fe) begin bad++; $display("FAIL fe_set got=%b exp=%b", link.framing_error, m_fe); end
      total++; if (link.byte_out !== m_out) begin bad++; $display("FAIL fe_byte_out got=%h exp=%h", link.byte_out, m_out); end
      total++; if (link.byte_ready !== m_ready) begin bad++; $display("FAIL fe_ready got=%b exp=%b", link.byte_ready, m_ready); end
      total++; if (strobe_cyc.size() !== 0) begin bad++; $display("FAIL fe_strobes got=%0d exp=0", strobe_cyc.size()); end
      total++; if (busy_cycles !== OVS * (DB + 1) + 2 * OVS) begin bad++; $display("FAIL fe_busy_cycles got=%0d exp=%0d", busy_cycles, OVS * (DB + 1) + 2 * OVS); end
      total++; if (link.busy !== 1'b0) begin bad++; $display("FAIL fe_busy_end got=%b exp=0", link.busy); end
      push_level(1'b1, 2);
      play(BIG, -1, 0);
      m_fe = 1'b0; m_ovr = 1'b0;
      total++; if (link.framing_error !== m_fe) begin bad++; $display("FAIL fe_clear got=%b exp=%b", link.framing_error, m_fe); end
   endtask

   task automatic test_overrun;
      push_level(1'b1, 2);
      play(BIG, 0, -1);
      m_ready = 1'b0;
      push_level(1'b1, 4);
      push_frame(8'h11, 1'b1);
      push_level(1'b1, 4);
      push_frame(8'h22, 1'b1);
      push_level(1'b1, 8);
      play(BIG, -1, -1);
      model_frame(8'h11, 1'b1, 1'b0);
      model_frame(8'h22, 1'b1, 1'b0);
      total++; if (strobe_cyc.size() !== 2) begin bad++; $display("FAIL ovr_strobe_count got=%0d exp=2", strobe_cyc.size()); end
      total++; if (link.byte_out !== m_out) begin bad++; $display("FAIL ovr_byte_out got=%h exp=%h", link.byte_out, m_out); end
      total++; if (link.overrun !== m_ovr) begin bad++; $display("FAIL ovr_set got=%b exp=%b", link.overrun, m_ovr); end
      push_level(1'b1, 2);
      play(BIG, 0, -1);
      m_ready = 1'b0;
      total++; if (link.byte_ready !== m_ready) begin bad++; $display("FAIL ovr_ack_ready got=%b exp=%b", link.byte_ready, m_ready); end
      total++; if (link.overrun !== m_ovr) begin bad++; $display("FAIL ovr_sticky got=%b exp=%b", link.overrun, m_ovr); end
   endtask

   task automatic test_back_to_back;
      int gap;
      push_level(1'b1, 2);
      play(BIG, 0, 0);
      m_ready = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
      push_level(1'b1, 4);
      push_frame(8'h00, 1'b1);
      push_frame(8'hFF, 1'b1);
      push_level(1'b1, 8);
      // Ack the first byte just after its strobe, while the second frame runs.
      play(BIG, 4 + STROBE_LAT + SYNC, -1);
      model_frame(8'h00, 1'b1, 1'b0);
      m_ready = 1'b0;
      model_frame(8'hFF, 1'b1, 1'b0);
      gap = (strobe_cyc.size() == 2) ? strobe_cyc[1] - strobe_cyc[0] : -1;
      total++; if (gap !== OVS * (DB + 2)) begin bad++; $display("FAIL b2b_gap got=%0d exp=%0d", gap, OVS * (DB + 2)); end
      total++; if ((strobe_dat.size() > 0 ? strobe_dat[0] : 8'hxx) !== 8'h00) begin bad++; $display("FAIL b2b_first got=%h exp=00", strobe_dat.size() > 0 ? strobe_dat[0] : 8'hxx); end
      total++; if ((strobe_dat.size() > 1 ? strobe_dat[1] : 8'hxx) !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%h exp=ff", strobe_dat.size() > 1 ? strobe_dat[1] : 8'hxx); end
      total++; if (n_samples !== 2 * DB) begin bad++; $display("FAIL b2b_samples got=%0d exp=%0d", n_samples, 2 * DB); end
      total++; if ({link.framing_error, link.overrun, link.byte_ready} !== {m_fe, m_ovr, m_ready}) begin bad++; $display("FAIL b2b_flags got=%b%b%b exp=%b%b%b", link.framing_error, link.overrun, link.byte_ready, m_fe, m_ovr, m_ready); end
   endtask

   task automatic test_same_cycle_events;
      logic [7:0] d;
      d = 8'($urandom);
      // byte_ready is 1 here; ack lands exactly on the stop-sample cycle.
      push_level(1'b1, 4);
      push_frame(d, 1'b1);
      push_level(1'b1, 8);
      play(BIG, 4 + STROBE_LAT - 1 + SYNC, -1);
      model_frame(d, 1'b1, 1'b1);
      total++; if (link.byte_ready !== m_ready) begin bad++; $display("FAIL ackmix_ready got=%b exp=%b", link.byte_ready, m_ready); end
      total++; if (link.overrun !== m_ovr) begin bad++; $display("FAIL ackmix_ovr got=%b exp=%b", link.overrun, m_ovr); end
      total++; if (link.byte_out !== m_out) begin bad++; $display("FAIL ackmix_byte_out got=%h exp=%h", link.byte_out, m_out); end
      // clear_errors on the cycle a framing error is detected: set wins.
      push_level(1'b1, 4);
      push_frame(8'($urandom), 1'b0);
      push_level(1'b1, 8);
      play(BIG, -1, 4 + STROBE_LAT - 1 + SYNC);
      m_ovr = 1'b0;
      m_fe  = 1'b1;
      total++; if (link.framing_error !== m_fe) begin bad++; $display("FAIL clrmix_fe got=%b exp=%b", link.framing_error, m_fe); end
      // clear_errors on the cycle an overrun occurs: set wins.
      d = 8'($urandom);
      push_level(1'b1, 4);
      push_frame(d, 1'b1);
      push_level(1'b1, 8);
      play(BIG, -1, 4 + STROBE_LAT - 1 + SYNC);
      m_fe = 1'b0;
      model_frame(d, 1'b1, 1'b0);
      total++; if (link.overrun !== m_ovr) begin bad++; $display("FAIL clrmix_ovr got=%b exp=%b", link.overrun, m_ovr); end
      total++; if (link.framing_error !== m_fe) begin bad++; $display("FAIL clrmix_fe_cleared got=%b exp=%b", link.framing_error, m_fe); end
   endtask

   task automatic test_reset_midframe;
      push_level(1'b1, 4);
      push_frame(8'h5A, 1'b1);
      push_level(1'b1, 8);
      play(4 + OVS * 5 + OVS / 2, -1, -1);
      reset = 1'b1;
      #1;
      total++; if (link.byte_out !== 8'h00) begin bad++; $display("FAIL rstmid_byte_out got=%h exp=00", link.byte_out); end
      total++; if ({link.byte_ready, link.busy, link.sample_bit, link.byte_strobe} !== 4'b0000) begin bad++; $display("FAIL rstmid_flags got=%b%b%b%b exp=0000", link.byte_ready, link.busy, link.sample_bit, link.byte_strobe); end
      total++; if ({link.framing_error, link.overrun} !== 2'b00) begin bad++; $display("FAIL rstmid_errors got=%b%b exp=00", link.framing_error, link.overrun); end
      m_out = 8'h00; m_ready = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
      line_q.delete();
      link.rx_serial = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      push_level(1'b1, 4);
      push_frame(8'h5A, 1'b1);
      push_level(1'b1, 8);
      play(BIG, -1, -1);
      model_frame(8'h5A, 1'b1, 1'b0);
      total++; if (strobe_cyc.size() !== 1) begin bad++; $display("FAIL rstmid_strobes got=%0d exp=1", strobe_cyc.size()); end
      total++; if (link.byte_out !== m_out) begin bad++; $display("FAIL rstmid_next_byte got=%h exp=%h", link.byte_out, m_out); end
      total++; if ({link.framing_error, link.overrun, link.byte_ready} !== {m_fe, m_ovr, m_ready}) begin bad++; $display("FAIL rstmid_next_flags got=%b%b%b exp=%b%b%b", link.framing_error, link.overrun, link.byte_ready, m_fe, m_ovr, m_ready); end
   endtask

   task automatic test_random;
      logic [7:0] d;
      bit do_ack, do_clr, good;
      for (int k = 0; k < 12; k++) begin
         d      = 8'($urandom);
         do_ack = ($urandom_range(0, 1) == 0);
         do_clr = ($urandom_range(0, 4) == 0);
         good   = ($urandom_range(0, 4) != 0);
         push_level(1'b1, $urandom_range(1, 12));
         push_frame(d, good);
         if (!good) push_level(1'b0, $urandom_range(0, 20));
         push_level(1'b1, 4);
         play(BIG, do_ack ? 0 : -1, do_clr ? 0 : -1);
         if (do_ack) m_ready = 1'b0;
         if (do_clr) begin m_fe = 1'b0; m_ovr = 1'b0; end
         model_frame(d, good, 1'b0);
         total++; if (n_samples !== DB) begin bad++; $display("FAIL rnd%0d_samples got=%0d exp=%0d", k, n_samples, DB); end
         total++; if (strobe_cyc.size() !== (good ? 1 : 0)) begin bad++; $display("FAIL rnd%0d_strobes got=%0d exp=%0d", k, strobe_cyc.size(), good ? 1 : 0); end
         total++; if (link.byte_out !== m_out) begin bad++; $display("FAIL rnd%0d_byte_out got=%h exp=%h", k, link.byte_out, m_out); end
         total++; if (link.byte_ready !== m_ready) begin bad++; $display("FAIL rnd%0d_ready got=%b exp=%b", k, link.byte_ready, m_ready); end
         total++; if (link.framing_error !== m_fe) begin bad++; $display("FAIL rnd%0d_fe got=%b exp=%b", k, link.framing_error, m_fe); end
         total++; if (link.overrun !== m_ovr) begin bad++; $display("FAIL rnd%0d_ovr got=%b exp=%b", k, link.overrun, m_ovr); end
      end
   endtask

   initial begin
      test_reset();
      test_single_a5();
      test_glitch();
      test_framing();
      test_overrun();
      test_back_to_back();
      test_same_cycle_events();
      test_reset_midframe();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/serial_byte_receiver.md
Name: serial_byte_receiver

Overview:
Receive front end for the inter-board serial link. It synchronises the RECIEVE pin and detects a start bit. It samples 8 data bits at mid-bit using 16x oversampling and checks the stop bit. It then presents each byte in parallel, with a one-cycle strobe and a ready/ack hold, to the CPU's curbytein/instrobe inputs, and it replaces the separate start-detect, stream-counter and shift-in stages.

Parameters:
OVERSAMPLE, 16, clocks per serial bit; power of two, at least 4
DATA_BITS, 8, data bits per frame, sent LSB first

Ports:
clock  input  1  system clock (divided design clock)
reset  input  1  asynchronous, active-high reset
rx_serial  input  1  raw serial line; idles high
byte_ack  input  1  one-cycle pulse from the CPU; consumes the held byte
clear_errors  input  1  clears the sticky error flags
byte_out  output  DATA_BITS  last good received byte
byte_strobe  output  1  one-cycle pulse when byte_out is updated
byte_ready  output  1  a good byte is held and not yet acked
busy  output  1  a frame is in progress (any state except IDLE)
sample_bit  output  1  one-cycle pulse at each data-bit sample point
framing_error  output  1  sticky; a stop bit was sampled low
overrun  output  1  sticky; a new byte completed while byte_ready was still 1

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, counters=0, shift register=0.
- Outputs at reset: byte_out=0; byte_strobe=busy=sample_bit=byte_ready=framing_error=overrun=0.
- Synchroniser flops reset to 1 (line idle).
- rx_serial passes through a 2-flop synchroniser; all logic uses only the synchronised signal rx_s.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: on the first cycle rx_s=0 (cycle 0), go to START with bit counter cleared.
- START: at cycle OVERSAMPLE/2-1 (7), re-sample rx_s.
  - rx_s=1: false start; return to IDLE with no outputs.
  - rx_s=0: go to DATA and clear the bit counter.
- DATA: sample rx_s every OVERSAMPLE clocks.
  - Data bit i is sampled at cycle 7+16*(i+1); sample_bit pulses that same cycle.
  - Each sample shifts right into the shift register (LSB first).
  - After DATA_BITS samples, go to STOP.
- STOP: sample rx_s at cycle 7+16*(DATA_BITS+1), which is 151 for defaults.
  - rx_s=1: byte_out <= shift register; byte_strobe=1 for the next cycle only (cycle 152).
  - Also on rx_s=1: byte_ready <= 1; if byte_ready was already 1, set overrun (byte_out is still overwritten); go to IDLE.
  - rx_s=0: byte_out and byte_ready are unchanged; set framing_error; go to BREAK.
- BREAK: wait until rx_s=1, then go to IDLE. A held-low line never produces a byte.
- Back-to-back frames: IDLE can detect a new start bit in the cycle after the stop sample.
- byte_ack clears byte_ready at the next edge.
- byte_ack in the same cycle a new byte completes: byte_ready stays 1 and overrun is not set (the ack consumed the old byte).
- byte_ack while byte_ready=0: ignored.
- clear_errors clears framing_error and overrun.
- clear_errors in the same cycle as a new error event: the set wins.
- busy=1 in START, DATA, STOP and BREAK.
- Counter width is $clog2(OVERSAMPLE); it wraps to 0 at each sample point. No count exceeds OVERSAMPLE-1.
- Reset mid-frame aborts the frame immediately. No strobe is produced and the partial byte is discarded.

Test Plan:
- Byte 0xA5 sent as start, 1,0,1,0,0,1,0,1 (LSB first), stop, at 16 clocks/bit: byte_strobe 1 at cycle 152 after start edge sync; byte_out=0xA5, byte_ready=1, 8 sample_bit pulses, no errors.
- 4-clock low glitch on an idle line: busy rises, then falls at cycle 8; no sample_bit, no strobe, byte_out unchanged.
- Frame 0x3C with stop bit held low for 32 clocks: framing_error=1, byte_out keeps its previous value, byte_ready unchanged, state BREAK until the line rises, then IDLE; clear_errors -> framing_error=0.
- Two frames 0x11 then 0x22 with no byte_ack: second strobe -> byte_out=0x22, overrun=1; byte_ack then -> byte_ready=0 while overrun stays 1.
- Back-to-back 0x00 and 0xFF with zero idle between stop and next start: both strobes occur 160 clocks apart; values correct; no errors.
- Reset asserted at mid data bit 4 of frame 0x5A: all outputs 0 immediately. The next clean frame 0x5A is received correctly.
